// File: rtl/fibonacci_req_master_pkg.sv
// Shared types for the Fibonacci request master: widths, FSM states and the result record.
package fib_pkg;

    localparam int IDX_W = 5;
    localparam int F_W   = 20;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT,
        DRAIN
    } state_e;

    typedef struct packed {
        logic [IDX_W-1:0] idx;
        logic [F_W-1:0]   f;
        logic             err;
    } result_t;

    function automatic result_t make_result(input logic [IDX_W-1:0] idx,
                                            input logic [F_W-1:0]   f,
                                            input logic             err);
        result_t r;
        r.idx = idx;
        r.f   = f;
        r.err = err;
        return r;
    endfunction

endpackage

// File: rtl/fibonacci_req_master_if.sv
// Command stream, core handshake and result stream seen by the request master.
interface fibonacci_req_master_if;
    import fib_pkg::*;

    logic             cmd_valid_i;
    logic             cmd_ready_o;
    logic [IDX_W-1:0] cmd_idx_i;
    logic             fib_start_o;
    logic [IDX_W-1:0] fib_i_o;
    logic             fib_ready_i;
    logic             fib_done_tick_i;
    logic [F_W-1:0]   fib_f_i;
    logic             res_valid_o;
    logic             res_ready_i;
    logic [IDX_W-1:0] res_idx_o;
    logic [F_W-1:0]   res_f_o;
    logic             res_err_o;
    logic             busy_o;

    modport master (
        input  cmd_valid_i, cmd_idx_i, fib_ready_i, fib_done_tick_i, fib_f_i, res_ready_i,
        output cmd_ready_o, fib_start_o, fib_i_o, res_valid_o, res_idx_o, res_f_o,
               res_err_o, busy_o
    );

    modport slave (
        output cmd_valid_i, cmd_idx_i, fib_ready_i, fib_done_tick_i, fib_f_i, res_ready_i,
        input  cmd_ready_o, fib_start_o, fib_i_o, res_valid_o, res_idx_o, res_f_o,
               res_err_o, busy_o
    );

endinterface

// File: rtl/fibonacci_req_master_fifo.sv
// Synchronous result FIFO; the head is read combinationally and stays put until popped.
module fib_res_fifo
    import fib_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic    clk,
    input  logic    rst,
    input  logic    push,
    input  logic    pop,
    input  result_t wr_data,
    output result_t rd_data,
    output logic    full,
    output logic    empty
);

    localparam int AW = $clog2(DEPTH);

    result_t       mem [DEPTH];
    logic [AW:0]   wr_ptr;
    logic [AW:0]   rd_ptr;
    logic          do_push;
    logic          do_pop;

    // The extra pointer bit separates full from empty when the slot addresses match.
    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign rd_data = mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr[AW-1:0]] <= wr_data;
    end

endmodule

// File: rtl/fibonacci_req_master.sv
// Issues one start pulse per accepted index to the Fibonacci core and queues tagged results.
module fibonacci_req_master
    import fib_pkg::*;
#(
    parameter int MAX_IDX     = 30,
    parameter int TIMEOUT_CYC = 255,
    parameter int FIFO_DEPTH  = 4
) (
    input logic                   clk_i,
    input logic                   rst_i,
    fibonacci_req_master_if.master bus
);

    localparam int               CNT_W    = $clog2(TIMEOUT_CYC + 1);
    localparam logic [IDX_W-1:0] MAX_IDXL = IDX_W'(MAX_IDX);
    localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(TIMEOUT_CYC - 1);

    state_e           state;
    logic [CNT_W-1:0] tmo_cnt;
    logic             accept;
    logic             push;
    result_t          push_data;
    result_t          head;
    logic             fifo_full;
    logic             fifo_empty;

    // Space is reserved at accept time, so every later push is guaranteed a free slot.
    assign bus.cmd_ready_o = !rst_i && (state == IDLE) && bus.fib_ready_i && !fifo_full;
    assign accept          = bus.cmd_valid_i && bus.cmd_ready_o;

    always_comb begin
        push      = 1'b0;
        push_data = '0;
        case (state)
            IDLE: begin
                if (accept && (bus.cmd_idx_i > MAX_IDXL)) begin
                    push      = 1'b1;
                    push_data = make_result(bus.cmd_idx_i, '0, 1'b1);
                end
            end
            WAIT: begin
                if (bus.fib_done_tick_i) begin
                    push      = 1'b1;
                    push_data = make_result(bus.fib_i_o, bus.fib_f_i, 1'b0);
                end else if (tmo_cnt == TMO_LAST) begin
                    push      = 1'b1;
                    push_data = make_result(bus.fib_i_o, '0, 1'b1);
                end
            end
            default: ;
        endcase
    end

    // tmo_cnt counts WAIT cycles, so the last WAIT cycle is TIMEOUT_CYC cycles after the start pulse.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state           <= IDLE;
            tmo_cnt         <= '0;
            bus.fib_start_o <= 1'b0;
            bus.fib_i_o     <= '0;
            bus.busy_o      <= 1'b0;
        end else begin
            bus.fib_start_o <= 1'b0;
            case (state)
                IDLE: begin
                    if (accept && (bus.cmd_idx_i <= MAX_IDXL)) begin
                        bus.fib_i_o     <= bus.cmd_idx_i;
                        bus.fib_start_o <= 1'b1;
                        bus.busy_o      <= 1'b1;
                        state           <= ISSUE;
                    end
                end
                ISSUE: begin
                    tmo_cnt <= '0;
                    state   <= WAIT;
                end
                WAIT: begin
                    if (bus.fib_done_tick_i) begin
                        bus.busy_o <= 1'b0;
                        state      <= IDLE;
                    end else if (tmo_cnt == TMO_LAST) begin
                        state <= DRAIN;
                    end else begin
                        tmo_cnt <= tmo_cnt + 1'b1;
                    end
                end
                DRAIN: begin
                    if (bus.fib_ready_i) begin
                        bus.busy_o <= 1'b0;
                        state      <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    fib_res_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk_i),
        .rst     (rst_i),
        .push    (push),
        .pop     (bus.res_ready_i),
        .wr_data (push_data),
        .rd_data (head),
        .full    (fifo_full),
        .empty   (fifo_empty)
    );

    assign bus.res_valid_o = !fifo_empty;
    assign bus.res_idx_o   = fifo_empty ? '0 : head.idx;
    assign bus.res_f_o     = fifo_empty ? '0 : head.f;
    assign bus.res_err_o   = fifo_empty ? 1'b0 : head.err;

endmodule

// File: tb/tb_fibonacci_req_master.sv
// Directed bench for fibonacci_req_master with a simple behavioural Fibonacci core.
module tb_fibonacci_req_master;
   import fib_pkg::*;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   fibonacci_req_master_if bus();

   fibonacci_req_master dut (
      .clk_i (clk),
      .rst_i (rst),
      .bus   (bus)
   );

   int n_vec  = 0;
   int n_miss = 0;

   // Core model state; only the model process writes these.
   logic           core_ready = 1'b1;
   logic           core_done  = 1'b0;
   logic [F_W-1:0] core_f     = '0;
   bit             core_busy  = 1'b0;
   int             start_cnt  = 0;
   int             lat_cnt    = 0;
   logic [IDX_W-1:0] core_idx = '0;

   // Knobs set by the main sequence.
   int core_lat    = 3;
   bit core_hang   = 1'b0;
   bit release_req = 1'b0;

   assign bus.fib_ready_i     = core_ready;
   assign bus.fib_done_tick_i = core_done;
   assign bus.fib_f_i         = core_f;

   function automatic logic [F_W-1:0] fib_model(input logic [IDX_W-1:0] n);
      logic [F_W-1:0] a = '0;
      logic [F_W-1:0] b = 1;
      logic [F_W-1:0] t;
      for (int i = 0; i < int'(n); i++) begin
         t = a + b;
         a = b;
         b = t;
      end
      return a;
   endfunction

   // A release while hung emits a stray done together with ready, which DRAIN must ignore.
   always @(posedge clk) begin
      #1;
      core_done = 1'b0;
      if (core_busy) begin
         if (release_req) begin
            core_done  = 1'b1;
            core_f     = 20'hABCDE;
            core_busy  = 1'b0;
            core_ready = 1'b1;
         end else if (!core_hang) begin
            if (lat_cnt == 0) begin
               core_done  = 1'b1;
               core_f     = fib_model(core_idx);
               core_busy  = 1'b0;
               core_ready = 1'b1;
            end else begin
               lat_cnt--;
            end
         end
      end else if (bus.fib_start_o) begin
         start_cnt++;
         core_busy  = 1'b1;
         core_ready = 1'b0;
         core_idx   = bus.fib_i_o;
         lat_cnt    = core_lat;
      end
   end

   task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      if (obs !== exp) begin
         n_miss++;
         $display("[TB] FAIL %s: got %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic applyStimulus(input logic [IDX_W-1:0] idx);
      int n = 0;
      bus.cmd_idx_i   = idx;
      bus.cmd_valid_i = 1'b1;
      @(negedge clk);
      while (!bus.cmd_ready_o && n < 400) begin
         @(negedge clk);
         n++;
      end
      checkOutput("cmd_accept", 32'(bus.cmd_ready_o), 1);
      @(posedge clk);
      #1;
      bus.cmd_valid_i = 1'b0;
   endtask

   task automatic popResult(input string tag, input logic [IDX_W-1:0] idx,
                            input logic [F_W-1:0] f, input logic err);
      int n = 0;
      @(negedge clk);
      while (!bus.res_valid_o && n < 400) begin
         @(negedge clk);
         n++;
      end
      checkOutput({tag, "_valid"}, 32'(bus.res_valid_o), 1);
      checkOutput({tag, "_idx"},   32'(bus.res_idx_o),   32'(idx));
      checkOutput({tag, "_f"},     32'(bus.res_f_o),     32'(f));
      checkOutput({tag, "_err"},   32'(bus.res_err_o),   32'(err));
      bus.res_ready_i = 1'b1;
      @(posedge clk);
      #1;
      bus.res_ready_i = 1'b0;
   endtask

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation did not finish");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      int n;
      bus.cmd_valid_i = 1'b0;
      bus.cmd_idx_i   = '0;
      bus.res_ready_i = 1'b0;

      // Reset values
      rst = 1'b1;
      repeat (2) @(posedge clk);
      @(negedge clk);
      checkOutput("rst_cmd_ready", 32'(bus.cmd_ready_o), 0);
      checkOutput("rst_start",     32'(bus.fib_start_o), 0);
      checkOutput("rst_fib_i",     32'(bus.fib_i_o),     0);
      checkOutput("rst_res_valid", 32'(bus.res_valid_o), 0);
      checkOutput("rst_res_idx",   32'(bus.res_idx_o),   0);
      checkOutput("rst_res_f",     32'(bus.res_f_o),     0);
      checkOutput("rst_res_err",   32'(bus.res_err_o),   0);
      checkOutput("rst_busy",      32'(bus.busy_o),      0);
      @(posedge clk);
      #1;
      rst = 1'b0;
      @(negedge clk);
      checkOutput("ready_after_rst", 32'(bus.cmd_ready_o), 1);

      // Single command idx=10
      @(posedge clk);
      #1;
      applyStimulus(5'd10);
      @(negedge clk);
      checkOutput("issue_start", 32'(bus.fib_start_o), 1);
      checkOutput("issue_fib_i", 32'(bus.fib_i_o),     10);
      checkOutput("issue_busy",  32'(bus.busy_o),      1);
      @(negedge clk);
      checkOutput("start_one_cycle", 32'(bus.fib_start_o), 0);
      popResult("idx10", 5'd10, 20'd55, 1'b0);
      checkOutput("idx10_starts", 32'(start_cnt), 1);
      @(negedge clk);
      checkOutput("idx10_fifo_empty", 32'(bus.res_valid_o), 0);

      // Back-to-back 0,1,20,30 with the consumer stalled, filling the FIFO
      @(posedge clk);
      #1;
      applyStimulus(5'd0);
      applyStimulus(5'd1);
      applyStimulus(5'd20);
      applyStimulus(5'd30);
      bus.cmd_idx_i   = 5'd5;
      bus.cmd_valid_i = 1'b1;
      repeat (12) @(negedge clk);
      checkOutput("full_cmd_ready", 32'(bus.cmd_ready_o), 0);
      checkOutput("full_busy",      32'(bus.busy_o),      0);
      checkOutput("full_starts",    32'(start_cnt),       5);
      popResult("b2b0", 5'd0, 20'd0, 1'b0);
      @(negedge clk);
      checkOutput("pop_reenables", 32'(bus.cmd_ready_o), 1);
      @(posedge clk);
      #1;
      bus.cmd_valid_i = 1'b0;
      popResult("b2b1",  5'd1,  20'd1,      1'b0);
      popResult("b2b20", 5'd20, 20'd6765,   1'b0);
      popResult("b2b30", 5'd30, 20'd832040, 1'b0);
      popResult("after_full5", 5'd5, 20'd5, 1'b0);
      @(negedge clk);
      checkOutput("b2b_no_dup", 32'(bus.res_valid_o), 0);
      checkOutput("b2b_starts", 32'(start_cnt),       6);

      // Out-of-range index
      @(posedge clk);
      #1;
      applyStimulus(5'd31);
      @(negedge clk);
      checkOutput("range_valid", 32'(bus.res_valid_o), 1);
      checkOutput("range_err",   32'(bus.res_err_o),   1);
      checkOutput("range_busy",  32'(bus.busy_o),      0);
      checkOutput("range_no_start", 32'(start_cnt),    6);
      popResult("range", 5'd31, 20'd0, 1'b0 | 1'b1);

      // Timeout: core never strobes done
      core_hang = 1'b1;
      @(posedge clk);
      #1;
      applyStimulus(5'd7);
      n = 0;
      @(negedge clk);
      while (!bus.res_valid_o && n < 300) begin
         n++;
         @(negedge clk);
      end
      checkOutput("tmo_cycles",    32'(n),               256);
      checkOutput("tmo_busy",      32'(bus.busy_o),      1);
      checkOutput("tmo_cmd_ready", 32'(bus.cmd_ready_o), 0);
      popResult("tmo", 5'd7, 20'd0, 1'b1);
      @(negedge clk);
      checkOutput("drain_busy", 32'(bus.busy_o), 1);
      core_hang   = 1'b0;
      release_req = 1'b1;
      repeat (3) @(negedge clk);
      release_req = 1'b0;
      checkOutput("drain_done_busy",  32'(bus.busy_o),      0);
      checkOutput("drain_late_done",  32'(bus.res_valid_o), 0);
      @(posedge clk);
      #1;
      applyStimulus(5'd12);
      popResult("post_tmo", 5'd12, 20'd144, 1'b0);

      // Reset while in WAIT with an entry queued
      core_lat = 20;
      @(posedge clk);
      #1;
      applyStimulus(5'd31);
      applyStimulus(5'd9);
      repeat (3) @(negedge clk);
      checkOutput("pre_rst_busy",  32'(bus.busy_o),      1);
      checkOutput("pre_rst_valid", 32'(bus.res_valid_o), 1);
      rst = 1'b1;
      @(negedge clk);
      checkOutput("midrst_busy",      32'(bus.busy_o),      0);
      checkOutput("midrst_start",     32'(bus.fib_start_o), 0);
      checkOutput("midrst_fib_i",     32'(bus.fib_i_o),     0);
      checkOutput("midrst_res_valid", 32'(bus.res_valid_o), 0);
      checkOutput("midrst_res_idx",   32'(bus.res_idx_o),   0);
      checkOutput("midrst_res_err",   32'(bus.res_err_o),   0);
      checkOutput("midrst_cmd_ready", 32'(bus.cmd_ready_o), 0);
      rst = 1'b0;
      repeat (30) @(negedge clk);
      checkOutput("late_done_ignored", 32'(bus.res_valid_o), 0);
      checkOutput("post_rst_busy",     32'(bus.busy_o),      0);
      checkOutput("post_rst_ready",    32'(bus.cmd_ready_o), 1);
      checkOutput("total_starts",      32'(start_cnt),       9);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end

endmodule
